// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder, one nibble per cycle; result valid NIBBLES cycles after accept.
// One operation in flight; result holds stable while out_ready is low and new requests wait.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op_a, op_b, sum;
  logic            carry, cmsb;
  logic [IW-1:0]   idx;
  logic [3:0]      nib_a, nib_b;
  logic [4:0]      nib_sum;
  logic            last_nib;

  assign nib_a    = op_a[{idx, 2'b00} +: 4];
  assign nib_b    = op_b[{idx, 2'b00} +: 4];
  assign nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry};
  assign last_nib = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ADD;
      ADD:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cmsb  <= 1'b0;
      idx   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_a  <= in_a;
          op_b  <= in_b;
          carry <= in_cin;
          sum   <= '0;
          idx   <= '0;
        end
        ADD: begin
          sum[{idx, 2'b00} +: 4] <= nib_sum[3:0];
          carry                  <= nib_sum[4];
          if (last_nib) begin
            // Sum bit 3 is a^b^carry_in, so the carry into the MSB falls out by XOR.
            cmsb <= nib_sum[3] ^ nib_a[3] ^ nib_b[3];
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum;
  assign out_cout  = carry;
  assign out_ovf   = cmsb ^ carry;
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder that sums two wide operands one 4-bit nibble per clock, LSB nibble first, through a single 4-bit add stage with a registered carry between nibbles. It accepts operand pairs on a valid/ready input and returns the full-width sum, carry-out and signed overflow on a valid/ready output. Logic cost is one nibble adder plus control, in exchange for NIBBLES cycles of latency.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES. Legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and carry-in present.
- in_ready  out  1  block can accept an operand pair; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry into nibble 0.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  consumer takes the result.
- out_sum  out  W  in_a + in_b + in_cin, modulo 2^W.
- out_cout  out  1  carry out of bit W-1.
- out_ovf  out  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.
- busy  out  1  high in ADD or DONE.

## Operation
- States: IDLE, ADD, DONE. Registers: opA, opB (W bits each), sum (W), carry (1), idx (ceil(log2 NIBBLES) bits), cmsb (carry into bit W-1).
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_a, in_b, set carry<=in_cin, idx<=0, sum<=0, and go to ADD. While in_valid=0, stay in IDLE.
- ADD, one nibble per cycle: {c, s} = opA[4*idx+3:4*idx] + opB[4*idx+3:4*idx] + carry, computed 5 bits wide. Then sum[4*idx+3:4*idx]<=s, carry<=c, idx<=idx+1.
- When idx==NIBBLES-1: also capture cmsb = carry into bit 3 of that nibble, then go to DONE. idx does not wrap past NIBBLES-1.
- DONE: out_valid=1. Output values: out_sum=sum, out_cout=carry, out_ovf=cmsb^carry. On out_ready, go to IDLE.
- in_ready=0 throughout ADD and DONE. in_valid, in_a, in_b and in_cin are ignored there, and no second request is queued.
- Backpressure: while out_valid=1 and out_ready=0, out_sum, out_cout and out_ovf hold stable.
- Outputs are registered or decoded from state only. No combinational path from in_* to out_*.
- out_sum, out_cout and out_ovf keep their last value in IDLE. They are meaningful only while out_valid=1.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, idx=0, carry=0.
- Reset during ADD or DONE aborts the operation. No result is emitted.
- Let the input handshake occur at rising edge k:
  - Edges k+1 .. k+NIBBLES each process one nibble.
  - out_valid is high in the cycle after edge k+NIBBLES, so latency is NIBBLES cycles from acceptance.
- With out_ready held high, out_valid is high for exactly one cycle. IDLE is re-entered at edge k+NIBBLES+1, and the next accept is possible at edge k+NIBBLES+2.
- Peak throughput is one operation per NIBBLES+2 cycles.
- If in_valid is already high when IDLE is entered, acceptance happens at the first edge in IDLE.
- The carry chain never spans more than one nibble per cycle. The critical path is one 4-bit add plus the nibble mux.

## Test plan
All cases use NIBBLES=4 unless noted.
- Basic add: in_a=0x1234, in_b=0x4321, in_cin=0.
  - Required: out_sum=0x5555, out_cout=0, out_ovf=0.
  - out_valid rises exactly 4 cycles after the input handshake.
- Full-width carry ripple: in_a=0xFFFF, in_b=0x0001, in_cin=0.
  - Required: out_sum=0x0000, out_cout=1, out_ovf=0.
- Signed overflow:
  - in_a=0x7FFF, in_b=0x0001: required out_sum=0x8000, out_cout=0, out_ovf=1.
  - in_a=0x8000, in_b=0x8000: required out_sum=0x0000, out_cout=1, out_ovf=1.
- Carry-in only: in_a=0x0000, in_b=0x0000, in_cin=1.
  - Required: out_sum=0x0001, out_cout=0, out_ovf=0.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with in_a=0xAAAA.
  - Required: outputs stable, in_ready=0, and the new request is not accepted.
  - Release out_ready: IDLE is entered on the next edge, and 0xAAAA is accepted on the edge after that.
- Reset mid-operation: assert rst_n=0 at the 2nd ADD cycle.
  - Required: in_ready=1, out_valid=0, busy=0 immediately.
  - After release, a fresh 0x0F0F+0xF0F1 yields out_sum=0x0000, out_cout=1, out_ovf=0.
